// File: rtl/seq_param_deser.sv
// seq_param_deser
//   Serial-to-parallel deserializer. Collects nbits serial bits (LSB first)
//   into a word and presents it downstream with a val/rdy handshake.
//   The held word can be handed off in the same cycle that the first bit of
//   the next word is accepted, so back-to-back words have no bubble.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   in_      serial data bit
//   in_val   in_ is valid this cycle
//   in_rdy   deserializer can accept in_ this cycle
//   out      assembled word; bit 0 is the first bit received
//   out_val  out holds a complete word
//   out_rdy  consumer accepts out this cycle
//
// State table
//   COLLECT | shifting bits into the word; cnt is the next bit position
//   HOLD    | complete word presented on out, waiting for out_rdy
module seq_param_deser #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [nbits-1:0] out,
  output logic             out_val,
  input  logic             out_rdy
);

  localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [nbits-1:0] word_q, word_d;

  logic xi;
  logic xo;

  assign out     = word_q;
  assign out_val = (state_q == HOLD);
  // out_rdy -> in_rdy is combinational: a held word leaving frees the slot.
  assign in_rdy  = (state_q == COLLECT) | ((state_q == HOLD) & out_rdy);

  assign xi = in_val & in_rdy;
  assign xo = out_val & out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;

    unique case (state_q)
      COLLECT: begin
        if (xi) begin
          if (cnt_q == '0) begin
            // First bit of a word clears any stale upper bits.
            word_d    = '0;
            word_d[0] = in_;
          end else begin
            for (int i = 1; i < nbits; i++) begin
              if (cnt_q == CW'(i)) word_d[i] = in_;
            end
          end
          if (cnt_q == CW'(nbits - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      HOLD: begin
        if (xo) begin
          if (xi) begin
            // Hand-off and first bit of the next word in the same cycle.
            word_d    = '0;
            word_d[0] = in_;
            if (nbits > 1) begin
              state_d = COLLECT;
              cnt_d   = CW'(1);
            end else begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end else begin
            state_d = COLLECT;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_param_deser.sv
module tb_seq_param_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance index: 0 -> nbits=4, 1 -> nbits=13, 2 -> nbits=1
  int nb [3] = '{4, 13, 1};

  logic rst  [3];
  logic ival [3];
  logic ibit [3];
  logic ordy [3];
  logic irdy [3];
  logic oval [3];
  logic [63:0] dout [3];

  logic [3:0]  o4;
  logic [12:0] o13;
  logic [0:0]  o1;

  assign dout[0] = 64'(o4);
  assign dout[1] = 64'(o13);
  assign dout[2] = 64'(o1);

  seq_param_deser #(.nbits(4)) u_n4 (
    .clk(clk), .reset(rst[0]), .in_(ibit[0]), .in_val(ival[0]), .in_rdy(irdy[0]),
    .out(o4), .out_val(oval[0]), .out_rdy(ordy[0]));

  seq_param_deser #(.nbits(13)) u_n13 (
    .clk(clk), .reset(rst[1]), .in_(ibit[1]), .in_val(ival[1]), .in_rdy(irdy[1]),
    .out(o13), .out_val(oval[1]), .out_rdy(ordy[1]));

  seq_param_deser #(.nbits(1)) u_n1 (
    .clk(clk), .reset(rst[2]), .in_(ibit[2]), .in_val(ival[2]), .in_rdy(irdy[2]),
    .out(o1), .out_val(oval[2]), .out_rdy(ordy[2]));

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a one-deep slot for a finished word plus a partial word
  // built from accepted bits by plain bit-position arithmetic.
  bit          m_hv [3];
  logic [63:0] m_held [3];
  logic [63:0] m_pw [3];
  int          m_pc [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_hv[k] = 0; m_held[k] = '0; m_pw[k] = '0; m_pc[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k] === 1'b1) begin
        m_hv[k] = 0; m_pw[k] = '0; m_pc[k] = 0;
      end else begin
        bit can_take;
        can_take = !m_hv[k] || ordy[k];
        if (m_hv[k] && ordy[k]) m_hv[k] = 0;
        if (ival[k] && can_take) begin
          m_pw[k] = m_pw[k] | (64'(ibit[k]) << m_pc[k]);
          m_pc[k] = m_pc[k] + 1;
          if (m_pc[k] == nb[k]) begin
            m_held[k] = m_pw[k];
            m_hv[k]   = 1;
            m_pw[k]   = '0;
            m_pc[k]   = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("n%0d out_val", nb[k]), 64'(oval[k]), 64'(m_hv[k]));
        check($sformatf("n%0d in_rdy", nb[k]), 64'(irdy[k]), 64'(!m_hv[k] || ordy[k]));
        if (m_hv[k]) check($sformatf("n%0d out", nb[k]), dout[k], m_held[k]);
      end
    end
  end

  task automatic drv(int k, bit v, bit b, bit r);
    @(posedge clk); #1;
    ival[k] = v; ibit[k] = b; ordy[k] = r;
  endtask

  task automatic lit(string nm, int k, bit v, logic [63:0] o, bit ir);
    @(negedge clk);
    check({nm, " out_val"}, 64'(oval[k]), 64'(v));
    if (v) check({nm, " out"}, dout[k], o);
    check({nm, " in_rdy"}, 64'(irdy[k]), 64'(ir));
  endtask

  initial begin
    bit s1 [4] = '{1, 0, 1, 1};
    bit s3 [4] = '{0, 1, 0, 1};
    bit s5 [4] = '{0, 0, 1, 0};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1; ival[k] = 0; ibit[k] = 0; ordy[k] = 1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_on = 1;
    for (int k = 0; k < 3; k++) rst[k] = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset out", dout[k], 64'h0);
      check("reset out_val", 64'(oval[k]), 64'h0);
      check("reset in_rdy", 64'(irdy[k]), 64'h1);
    end

    // Word 1101 with consumer always ready.
    for (int i = 0; i < 4; i++) drv(0, 1, s1[i], 1);
    drv(0, 0, 0, 1);
    lit("t1 word", 0, 1, 64'hD, 1);
    drv(0, 0, 0, 1);
    lit("t1 drained", 0, 0, 64'h0, 1);

    // Back-to-back words 0000 then 0001, no idle cycle.
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, (i == 4), 1);
      if (i == 4) lit("t2 first", 0, 1, 64'h0, 1);
    end
    drv(0, 0, 0, 1);
    lit("t2 second", 0, 1, 64'h1, 1);
    drv(0, 0, 0, 1);

    // Word 1010 held through a 3-cycle stall while in_ is offered.
    for (int i = 0; i < 4; i++) drv(0, 1, s3[i], 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 1, 0);
      lit("t3 stall", 0, 1, 64'hA, 0);
    end
    drv(0, 0, 0, 1);
    lit("t3 release", 0, 1, 64'hA, 1);
    drv(0, 0, 0, 1);
    lit("t3 done", 0, 0, 64'h0, 1);

    // nbits=13 with in_val toggling: 1 then twelve 0s.
    for (int i = 0; i < 13; i++) begin
      drv(1, 1, (i == 0), 1);
      drv(1, 0, 1'($urandom), 1);
    end
    lit("t4 n13", 1, 1, 64'h0001, 1);
    drv(1, 0, 0, 1);

    // Reset after two bits; new word 0100 must not see them.
    drv(0, 1, 1, 1);
    drv(0, 1, 1, 1);
    @(posedge clk); #1;
    rst[0] = 1; ival[0] = 1; ibit[0] = 1;
    @(posedge clk); #1;
    rst[0] = 0; ival[0] = 0;
    lit("t5 after reset", 0, 0, 64'h0, 1);
    check("t5 out cleared", dout[0], 64'h0);
    for (int i = 0; i < 4; i++) drv(0, 1, s5[i], 1);
    drv(0, 0, 0, 1);
    lit("t5 word", 0, 1, 64'h4, 1);
    drv(0, 0, 0, 1);

    // nbits=1: stream 1,0,1 gives out_val on three consecutive cycles.
    drv(2, 1, 1, 1);
    drv(2, 1, 0, 1);
    lit("t6 w0", 2, 1, 64'h1, 1);
    drv(2, 1, 1, 1);
    lit("t6 w1", 2, 1, 64'h0, 1);
    drv(2, 0, 0, 1);
    lit("t6 w2", 2, 1, 64'h1, 1);
    drv(2, 0, 0, 1);

    // Randomized traffic on all instances with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        rst[k]  = ($urandom_range(0, 199) == 0);
        ival[k] = ($urandom_range(0, 3) != 0);
        ibit[k] = 1'($urandom);
        ordy[k] = ($urandom_range(0, 2) != 0);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 0; ival[k] = 0; ordy[k] = 1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_param_deser.md
Name: seq_param_deser

Overview:
- Parameterized serial-to-parallel deserializer that assembles an nbits-wide word from a 1-bit stream, LSB first.
- Sits directly upstream of the parameterized nbits NOR (zero-detect) stage: its out port drives that stage's in_ port, qualified by out_val.
- Uses val/rdy handshakes on both sides, so upstream and downstream can stall independently.
- Supports back-to-back words with no bubble when the consumer is always ready.

Parameters:
- nbits, 8, output word width in bits; legal range 1..64.

Ports:
- clk      input   1      clock; all state updates on rising edge
- reset    input   1      synchronous, active-high reset
- in_      input   1      serial data bit
- in_val   input   1      in_ is valid this cycle
- in_rdy   output  1      deserializer can accept in_ this cycle
- out      output  nbits  assembled word, LSB = first bit received
- out_val  output  1      out holds a complete word
- out_rdy  input   1      consumer accepts out this cycle

Behaviour:
- Internal state:
  - word register, nbits wide.
  - bit counter cnt, width $clog2(nbits) with a minimum of 1, range 0..nbits-1.
  - FSM state: COLLECT or HOLD.
- Reset (sync, active-high, at posedge with reset=1):
  - state=COLLECT, cnt=0, word=0.
  - Outputs: out=0, out_val=0, in_rdy=1 in the first cycle after reset.
  - Reset mid-word discards the partial word.
  - Reset while in HOLD drops the held word without a transfer.
- Combinational outputs:
  - out = word register.
  - out_val = (state==HOLD).
  - in_rdy = (state==COLLECT) | (state==HOLD & out_rdy).
- Transfers: input transfer xi = in_val & in_rdy; output transfer xo = out_val & out_rdy.
- COLLECT:
  - On xi with cnt==0: word <= {0..0, in_}, so all upper bits are cleared.
  - On xi with cnt>0: word[cnt] <= in_.
  - On xi with cnt==nbits-1: state <= HOLD, cnt <= 0. Otherwise cnt <= cnt+1.
  - No xi: no change.
- HOLD:
  - word is frozen while out_val=1 and out_rdy=0; out must be stable across stalls.
  - xo without xi: state <= COLLECT, cnt <= 0.
  - xo with xi (pipelined): the new bit becomes bit 0 of the next word; word <= {0..0, in_}.
    - nbits>1: state <= COLLECT, cnt <= 1.
    - nbits==1: stay in HOLD with the new word, so out_val stays 1 on consecutive cycles.
- Latency: out_val rises the cycle after the nbits-th bit is accepted.
- Throughput: one word per nbits cycles with in_val=1 and out_rdy=1 continuously.
- While in COLLECT, out shows the partially assembled word; unreceived bits read 0. Consumers must qualify out with out_val.
- Gaps in in_val are allowed anywhere within a word; cnt holds across the gaps.
- No combinational path from in_val to out_val. out_rdy -> in_rdy is combinational.

Test Plan:
- nbits=4, reset then in_val=1 with bits 1,0,1,1, out_rdy=1 -> out_val=1 one cycle after the 4th bit, out=4'b1101, in_rdy stays 1, out_val=0 the following cycle.
- nbits=4, bits 0,0,0,0 then 1,0,0,0 back-to-back, out_rdy=1 -> out=4'b0000 then 4'b0001 (NOR stage out 1 then 0), no idle cycles between words.
- nbits=4, complete word 4'b1010 with out_rdy=0 for 3 cycles -> out_val=1 and out=4'b1010 stable, in_rdy=0 and in_ ignored, transfer only when out_rdy=1.
- nbits=13, in_val toggling 1/0, bit stream 1 followed by twelve 0s -> out=13'h0001 after 13 accepted bits, cnt holds during gaps.
- nbits=4, assert reset after 2 bits (1,1) accepted, then send 0,0,1,0 -> out=4'b0100, no leakage of the earlier bits.
- nbits=1, in_val=1 with stream 1,0,1 and out_rdy=1 -> out_val=1 on three consecutive cycles with out=1,0,1.
